inst_fetch_ctrl: RTL and testbench

//  Instruction-fetch control stage between the PC register and the decode stage.

---
 rtl/inst_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch control: one bus request per PC, captures the returned word and
// hands {if_pc, if_inst} to decode. Optional misaligned-fetch detection under IF_ADDR_EXC_EN.
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hbfc00000,
   parameter logic [31:0] NOP_INST = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic        pc_en,
   input  logic        flush,
   input  logic        id_allowin,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
`ifdef IF_ADDR_EXC_EN
   ,
   output logic        if_adel
`endif
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      WAIT    = 3'd2,
      DISCARD = 3'd3,
      HOLD    = 3'd4
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_lat_reg, pc_lat_next;
   logic        valid_reg, valid_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] inst_reg, inst_next;
   logic        misaligned;

`ifdef IF_ADDR_EXC_EN
   logic        adel_reg, adel_next;
   assign misaligned = (pc_in[1:0] != 2'b00);
   assign if_adel    = adel_reg;
`else
   assign misaligned = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         pc_lat_reg <= RESET_PC;
         valid_reg  <= 1'b0;
         pc_reg     <= RESET_PC;
         inst_reg   <= NOP_INST;
`ifdef IF_ADDR_EXC_EN
         adel_reg   <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         pc_lat_reg <= pc_lat_next;
         valid_reg  <= valid_next;
         pc_reg     <= pc_next;
         inst_reg   <= inst_next;
`ifdef IF_ADDR_EXC_EN
         adel_reg   <= adel_next;
`endif
      end
   end

   always_comb begin
      state_next  = state_reg;
      pc_lat_next = pc_lat_reg;
      valid_next  = valid_reg;
      pc_next     = pc_reg;
      inst_next   = inst_reg;
`ifdef IF_ADDR_EXC_EN
      adel_next   = adel_reg;
`endif
      inst_req    = 1'b0;
      // A misaligned PC advances without a bus request; flush simply redirects it.
      pc_en       = ((state_reg == REQ) && (inst_addr_ok || misaligned) && !flush)
                    || (flush && (state_reg != IDLE));
      case (state_reg)
         IDLE: state_next = REQ;
         REQ: begin
            if (misaligned) begin
               if (!flush) begin
                  valid_next = 1'b1;
                  pc_next    = pc_in;
                  inst_next  = NOP_INST;
`ifdef IF_ADDR_EXC_EN
                  adel_next  = 1'b1;
`endif
                  state_next = HOLD;
               end
            end else begin
               inst_req = 1'b1;
               if (inst_addr_ok) begin
                  if (flush) begin
                     state_next = DISCARD;
                  end else begin
                     pc_lat_next = pc_in;
                     state_next  = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            if (flush) begin
               state_next = inst_data_ok ? REQ : DISCARD;
            end else if (inst_data_ok) begin
               valid_next = 1'b1;
               pc_next    = pc_lat_reg;
               inst_next  = inst_rdata;
               state_next = HOLD;
            end
         end
         DISCARD: begin
            if (inst_data_ok) state_next = REQ;
         end
         HOLD: begin
            if (flush || id_allowin) begin
               valid_next = 1'b0;
               inst_next  = NOP_INST;
`ifdef IF_ADDR_EXC_EN
               adel_next  = 1'b0;
`endif
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign inst_addr = pc_in;
   assign if_valid  = valid_reg;
   assign if_pc     = pc_reg;
   assign if_inst   = inst_reg;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: per-cycle vector table plus hand-written
// async-reset and misaligned-fetch sequences.
module tb_inst_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_en;
   logic        flush;
   logic        id_allowin;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
`ifdef IF_ADDR_EXC_EN
   logic        if_adel;
`endif

   int pass_count  = 0;
   int check_count = 0;

   always #5 clk = ~clk;

   inst_fetch_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .pc_in        (pc_in),
      .pc_en        (pc_en),
      .flush        (flush),
      .id_allowin   (id_allowin),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .if_inst      (if_inst)
`ifdef IF_ADDR_EXC_EN
      ,
      .if_adel      (if_adel)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic        fl;
      logic        allow;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
      logic        e_pc_en;
      logic        e_req;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [31:0] pc, input logic fl, input logic allow,
                      input logic aok, input logic dok, input logic [31:0] rdata,
                      input logic e_pc_en, input logic e_req, input logic e_valid,
                      input logic [31:0] e_pc, input logic [31:0] e_inst);
      vec_t v;
      v.pc = pc; v.fl = fl; v.allow = allow; v.aok = aok; v.dok = dok; v.rdata = rdata;
      v.e_pc_en = e_pc_en; v.e_req = e_req; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic [31:0] pc, input logic fl, input logic allow,
                        input logic aok, input logic dok, input logic [31:0] rdata);
      pc_in = pc; flush = fl; id_allowin = allow;
      inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rdata;
   endtask

   initial begin
      rst = 1'b0;
      drive(32'hbfc00000, 0, 0, 0, 0, 32'h0);

      // pc        fl al ao do rdata          pc_en req | valid  if_pc        if_inst
      add(32'hbfc00000, 0, 0, 1, 0, 32'h0,        0, 0, 0, 32'hbfc00000, 32'h0);         // IDLE
      add(32'hbfc00000, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00000, 32'h0);         // REQ accepted
      add(32'hbfc00004, 0, 0, 0, 1, 32'h24080001, 0, 0, 1, 32'hbfc00000, 32'h24080001);  // WAIT data
      for (int i = 0; i < 4; i++)
         add(32'hbfc00004, 0, 0, 1, 1, 32'h11111111, 0, 0, 1, 32'hbfc00000, 32'h24080001); // HOLD stall
      add(32'hbfc00004, 0, 1, 0, 0, 32'h0,        0, 0, 0, 32'hbfc00000, 32'h0);         // consumed
      add(32'hbfc00004, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00000, 32'h0);         // REQ
      add(32'hbfc00008, 1, 0, 0, 0, 32'h0,        1, 0, 0, 32'hbfc00000, 32'h0);         // flush in WAIT
      add(32'hbfc00100, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hbfc00000, 32'h0);         // DISCARD
      add(32'hbfc00100, 0, 0, 0, 1, 32'hdeadbeef, 0, 0, 0, 32'hbfc00000, 32'h0);         // stale data dropped
      add(32'hbfc00100, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00000, 32'h0);         // REQ target
      add(32'hbfc00104, 0, 0, 0, 1, 32'h8c220004, 0, 0, 1, 32'hbfc00100, 32'h8c220004);
      add(32'hbfc00104, 0, 1, 0, 0, 32'h0,        0, 0, 0, 32'hbfc00100, 32'h0);
      add(32'hbfc00104, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00100, 32'h0);
      add(32'hbfc00108, 1, 0, 0, 1, 32'hcafef00d, 1, 0, 0, 32'hbfc00100, 32'h0);         // flush+data in WAIT
      add(32'hbfc00200, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'hbfc00100, 32'h0);         // REQ no addr_ok
      add(32'hbfc00200, 1, 0, 0, 0, 32'h0,        1, 1, 0, 32'hbfc00100, 32'h0);         // REQ flush, stay
      add(32'hbfc00300, 1, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00100, 32'h0);         // REQ addr_ok+flush
      add(32'hbfc00300, 0, 0, 0, 1, 32'hbadbadba, 0, 0, 0, 32'hbfc00100, 32'h0);         // DISCARD drop
      add(32'hbfc00300, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00100, 32'h0);
      add(32'hbfc00304, 0, 0, 0, 1, 32'h00000020, 0, 0, 1, 32'hbfc00300, 32'h00000020);
      add(32'hbfc00304, 1, 0, 0, 0, 32'h0,        1, 0, 0, 32'hbfc00300, 32'h0);         // flush in HOLD
      add(32'hbfc00400, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'hbfc00300, 32'h0);
      add(32'hbfc00400, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'hbfc00300, 32'h0);         // -> WAIT

      repeat (2) @(posedge clk);
      #1;
      chk("reset if_valid", {31'b0, if_valid}, 32'h0);
      chk("reset if_pc", if_pc, 32'hbfc00000);
      chk("reset if_inst", if_inst, 32'h0);
      chk("reset inst_req", {31'b0, inst_req}, 32'h0);
`ifdef IF_ADDR_EXC_EN
      chk("reset if_adel", {31'b0, if_adel}, 32'h0);
`endif
      rst = 1'b1;

      for (int k = 0; k < vq.size(); k++) begin
         drive(vq[k].pc, vq[k].fl, vq[k].allow, vq[k].aok, vq[k].dok, vq[k].rdata);
         #1;
         chk($sformatf("v%0d pc_en", k), {31'b0, pc_en}, {31'b0, vq[k].e_pc_en});
         chk($sformatf("v%0d inst_req", k), {31'b0, inst_req}, {31'b0, vq[k].e_req});
         if (vq[k].e_req) chk($sformatf("v%0d inst_addr", k), inst_addr, vq[k].pc);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d if_valid", k), {31'b0, if_valid}, {31'b0, vq[k].e_valid});
         chk($sformatf("v%0d if_pc", k), if_pc, vq[k].e_pc);
         chk($sformatf("v%0d if_inst", k), if_inst, vq[k].e_inst);
         $display("vec %0d: pc_in=%h flush=%b pc_en=%b req=%b valid=%b if_pc=%h if_inst=%h",
                  k, vq[k].pc, vq[k].fl, pc_en, inst_req, if_valid, if_pc, if_inst);
      end

      // Asynchronous reset while in WAIT, then a late data_ok that must be ignored.
      drive(32'hbfc00404, 0, 0, 0, 0, 32'h0);
      #2;
      rst = 1'b0;
      #1;
      chk("async if_pc", if_pc, 32'hbfc00000);
      chk("async if_valid", {31'b0, if_valid}, 32'h0);
      chk("async if_inst", if_inst, 32'h0);
      chk("async inst_req", {31'b0, inst_req}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(32'hbfc00000, 0, 0, 0, 1, 32'hdeadbeef);
      #1;
      chk("post-rst idle req", {31'b0, inst_req}, 32'h0);
      @(posedge clk);
      #1;
      chk("post-rst idle valid", {31'b0, if_valid}, 32'h0);
      drive(32'hbfc00000, 0, 0, 0, 1, 32'hdeadbeef);
      #1;
      chk("post-rst req", {31'b0, inst_req}, 32'h1);
      chk("post-rst pc_en", {31'b0, pc_en}, 32'h0);
      @(posedge clk);
      #1;
      chk("post-rst late data valid", {31'b0, if_valid}, 32'h0);
      chk("post-rst late data inst", if_inst, 32'h0);
      drive(32'hbfc00000, 0, 0, 1, 0, 32'h0);
      #1;
      chk("recover pc_en", {31'b0, pc_en}, 32'h1);
      @(posedge clk);
      #1;
      drive(32'hbfc00004, 0, 0, 0, 1, 32'h12345678);
      @(posedge clk);
      #1;
      chk("recover valid", {31'b0, if_valid}, 32'h1);
      chk("recover if_pc", if_pc, 32'hbfc00000);
      chk("recover if_inst", if_inst, 32'h12345678);
      $display("async reset sequence: if_valid=%b if_pc=%h if_inst=%h", if_valid, if_pc, if_inst);
      drive(32'hbfc00004, 0, 1, 0, 0, 32'h0);
      @(posedge clk);
      #1;

`ifdef IF_ADDR_EXC_EN
      // Now in REQ: a misaligned PC raises if_adel without touching the bus.
      drive(32'hbfc00002, 0, 0, 1, 0, 32'h0);
      #1;
      chk("adel inst_req", {31'b0, inst_req}, 32'h0);
      chk("adel pc_en", {31'b0, pc_en}, 32'h1);
      @(posedge clk);
      #1;
      chk("adel flag", {31'b0, if_adel}, 32'h1);
      chk("adel valid", {31'b0, if_valid}, 32'h1);
      chk("adel if_pc", if_pc, 32'hbfc00002);
      chk("adel if_inst", if_inst, 32'h0);
      drive(32'hbfc00002, 0, 1, 0, 0, 32'h0);
      @(posedge clk);
      #1;
      chk("adel cleared", {31'b0, if_adel}, 32'h0);
      chk("adel valid cleared", {31'b0, if_valid}, 32'h0);
      $display("misaligned fetch: if_adel cleared=%b", if_adel);
`endif

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
